// File: rtl/funct_seq_unit.sv
// ID-stage ALU function-code generator with a registered ID->EX slot and HI/LO busy sequencing.
// Optional FUNCT_SEQ_RI_EN adds the ri_exc output and reserved-instruction detection.
module funct_seq_unit #(
    parameter int unsigned OP_W       = 6,
    parameter int unsigned FUNCT_W    = 6,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FUNCT_W-1:0] funct,
    output logic               out_multi,
    output logic               busy
`ifdef FUNCT_SEQ_RI_EN
    ,
    output logic               ri_exc
`endif
);

    localparam logic [OP_W-1:0] OP_SPECIAL = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_JAL     = OP_W'(6'h03);
    localparam logic [OP_W-1:0] OP_ADDI    = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_ADDIU   = OP_W'(6'h09);
    localparam logic [OP_W-1:0] OP_SLTI    = OP_W'(6'h0a);
    localparam logic [OP_W-1:0] OP_SLTIU   = OP_W'(6'h0b);
    localparam logic [OP_W-1:0] OP_ANDI    = OP_W'(6'h0c);
    localparam logic [OP_W-1:0] OP_ORI     = OP_W'(6'h0d);
    localparam logic [OP_W-1:0] OP_XORI    = OP_W'(6'h0e);
    localparam logic [OP_W-1:0] OP_LUI     = OP_W'(6'h0f);
    localparam logic [OP_W-1:0] OP_LB      = OP_W'(6'h20);
    localparam logic [OP_W-1:0] OP_LH      = OP_W'(6'h21);
    localparam logic [OP_W-1:0] OP_LW      = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_LBU     = OP_W'(6'h24);
    localparam logic [OP_W-1:0] OP_LHU     = OP_W'(6'h25);
    localparam logic [OP_W-1:0] OP_SB      = OP_W'(6'h28);
    localparam logic [OP_W-1:0] OP_SH      = OP_W'(6'h29);
    localparam logic [OP_W-1:0] OP_SW      = OP_W'(6'h2b);

    // ALU codes share the MIPS funct field encoding; NOP is sll $0,$0,0.
    localparam logic [FUNCT_W-1:0] FUNCT_NOP   = FUNCT_W'(6'h00);
    localparam logic [FUNCT_W-1:0] FUNCT_MULT  = FUNCT_W'(6'h18);
    localparam logic [FUNCT_W-1:0] FUNCT_MULTU = FUNCT_W'(6'h19);
    localparam logic [FUNCT_W-1:0] FUNCT_DIV   = FUNCT_W'(6'h1a);
    localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = FUNCT_W'(6'h1b);
    localparam logic [FUNCT_W-1:0] FUNCT_ADD   = FUNCT_W'(6'h20);
    localparam logic [FUNCT_W-1:0] FUNCT_ADDU  = FUNCT_W'(6'h21);
    localparam logic [FUNCT_W-1:0] FUNCT_AND   = FUNCT_W'(6'h24);
    localparam logic [FUNCT_W-1:0] FUNCT_OR    = FUNCT_W'(6'h25);
    localparam logic [FUNCT_W-1:0] FUNCT_XOR   = FUNCT_W'(6'h26);
    localparam logic [FUNCT_W-1:0] FUNCT_SLT   = FUNCT_W'(6'h2a);
    localparam logic [FUNCT_W-1:0] FUNCT_SLTU  = FUNCT_W'(6'h2b);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [0:0] {IDLE, BUSY} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [FUNCT_W-1:0] dec_funct;
    logic               dec_multi;
    logic               accept, handoff, slot_is_mul;
`ifdef FUNCT_SEQ_RI_EN
    logic               dec_ri, special_known;
`endif

    assign accept      = in_valid && in_ready;
    assign handoff     = out_valid && out_ready;
    assign slot_is_mul = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    assign dec_multi   = (op == OP_SPECIAL) &&
                         (funct_in inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU});

`ifdef FUNCT_SEQ_RI_EN
    assign special_known = funct_in inside {
        FUNCT_W'(6'h00), FUNCT_W'(6'h02), FUNCT_W'(6'h03), FUNCT_W'(6'h04),
        FUNCT_W'(6'h06), FUNCT_W'(6'h07), FUNCT_W'(6'h08), FUNCT_W'(6'h09),
        FUNCT_W'(6'h10), FUNCT_W'(6'h11), FUNCT_W'(6'h12), FUNCT_W'(6'h13),
        FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
        FUNCT_ADD, FUNCT_ADDU, FUNCT_W'(6'h22), FUNCT_W'(6'h23),
        FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_W'(6'h27), FUNCT_SLT, FUNCT_SLTU};
`endif

    // Opcode to ALU function decode.
    always_comb begin
        dec_funct = FUNCT_NOP;
`ifdef FUNCT_SEQ_RI_EN
        dec_ri    = 1'b0;
`endif
        case (op)
            OP_SPECIAL: begin
                dec_funct = funct_in;
`ifdef FUNCT_SEQ_RI_EN
                if (!special_known) begin
                    dec_funct = FUNCT_NOP;
                    dec_ri    = 1'b1;
                end
`endif
            end
            OP_LUI, OP_ORI, OP_JAL: dec_funct = FUNCT_OR;
            OP_ANDI:                dec_funct = FUNCT_AND;
            OP_XORI:                dec_funct = FUNCT_XOR;
            OP_ADDI:                dec_funct = FUNCT_ADD;
            OP_SLTI:                dec_funct = FUNCT_SLT;
            OP_SLTIU:               dec_funct = FUNCT_SLTU;
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
            OP_SB, OP_SH, OP_SW, OP_ADDIU: dec_funct = FUNCT_ADDU;
            default: begin
                dec_funct = FUNCT_NOP;
`ifdef FUNCT_SEQ_RI_EN
                dec_ri    = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A flush aborts sequencing; a multi op handed off (without flush) starts it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handoff && out_multi) begin
                        state_nxt = BUSY;
                        cnt_nxt   = slot_is_mul ? MUL_LOAD : DIV_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt == '0) state_nxt = IDLE;
                    else           cnt_nxt   = cnt - CNT_W'(1);
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // A multi op still in the slot blocks accept so it cannot be overtaken before BUSY.
    always_comb begin
        busy     = (state == BUSY);
        in_ready = !flush && (state == IDLE) && (!out_valid || out_ready) &&
                   !(out_valid && out_multi);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            funct     <= FUNCT_NOP;
            out_multi <= 1'b0;
`ifdef FUNCT_SEQ_RI_EN
            ri_exc    <= 1'b0;
`endif
        end else if (flush) begin
            out_valid <= 1'b0;
            out_multi <= 1'b0;
`ifdef FUNCT_SEQ_RI_EN
            ri_exc    <= 1'b0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            funct     <= dec_funct;
            out_multi <= dec_multi;
`ifdef FUNCT_SEQ_RI_EN
            ri_exc    <= dec_ri;
`endif
        end else if (handoff) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_funct_seq_unit.sv
// Scoreboard bench for funct_seq_unit: directed vectors, expected slots queued at accept,
// popped and compared by a monitor at each handoff.
module tb_funct_seq_unit;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, out_ready;
    logic       in_ready, out_valid, out_multi, busy;
    logic [5:0] op, funct_in, funct;
`ifdef FUNCT_SEQ_RI_EN
    logic       ri_exc;
    localparam bit RI = 1'b1;
`else
    localparam bit RI = 1'b0;
`endif

    funct_seq_unit dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .funct_in(funct_in),
        .out_valid(out_valid), .out_ready(out_ready), .funct(funct),
        .out_multi(out_multi), .busy(busy)
`ifdef FUNCT_SEQ_RI_EN
        , .ri_exc(ri_exc)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [5:0] f;
        logic       m;
        logic       ri;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Handoff monitor
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%0h required=none", funct);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_funct", 32'(funct), 32'(mon_e.f));
                chk("sb_multi", 32'(out_multi), 32'(mon_e.m));
`ifdef FUNCT_SEQ_RI_EN
                chk("sb_ri", 32'(ri_exc), 32'(mon_e.ri));
`endif
            end
        end
    end

    task automatic send(input logic [5:0] o, input logic [5:0] f, input logic [5:0] ef,
                        input logic em, input logic er, input bit push, output int acc_cyc);
        int n;
        n = 0;
        acc_cyc = -1;
        op = o;
        funct_in = f;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=in_ready_low required=accept");
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        acc_cyc = cyc;
        if (push) sb.push_back('{ef, em, er});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic measure(output int len, output int last);
        int n;
        n = 0;
        len = 0;
        last = 0;
        while (!busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (busy && len < 200) begin
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            len++;
            last = cyc;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [5:0] o;
        logic [5:0] f;
        logic [5:0] ef;
        logic       ri;
    } vec_t;
    vec_t vt[10];

    logic [5:0] s_ops[4];
    logic [5:0] s_exp[4];

    initial begin
        int a, b, len, last, n;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 6'h00; funct_in = 6'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_funct", 32'(funct), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_multi", 32'(out_multi), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back stream: LW, ANDI, LUI, SLTIU
        s_ops = '{6'h23, 6'h0c, 6'h0f, 6'h0b};
        s_exp = '{6'h21, 6'h24, 6'h25, 6'h2b};
        for (int i = 0; i < 4; i++) begin
            op = s_ops[i];
            funct_in = 6'h00;
            in_valid = 1'b1;
            @(negedge clk);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            if (i > 0) begin
                chk("stream_valid", 32'(out_valid), 32'd1);
                chk("stream_funct", 32'(funct), 32'(s_exp[i-1]));
            end
            sb.push_back('{s_exp[i], 1'b0, 1'b0});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_last_funct", 32'(funct), 32'h2b);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stream_drain", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Stall: ADDIU held for 3 cycles
        out_ready = 1'b0;
        send(6'h09, 6'h00, 6'h21, 1'b0, 1'b0, 1'b1, a);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_funct", 32'(funct), 32'h21);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("stall_handoff_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_cleared", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // DIV: 32 busy cycles, next ADDIU accepted right after
        send(6'h00, 6'h1a, 6'h1a, 1'b1, 1'b0, 1'b1, a);
        fork
            measure(len, last);
            send(6'h09, 6'h00, 6'h21, 1'b0, 1'b0, 1'b1, b);
        join
        chk("div_busy_len", 32'(len), 32'd32);
        chk("div_next_accept", 32'(b), 32'(last + 1));

        // MULT: 4 busy cycles
        send(6'h00, 6'h18, 6'h18, 1'b1, 1'b0, 1'b1, a);
        measure(len, last);
        chk("mult_busy_len", 32'(len), 32'd4);
        @(posedge clk);
        #1;

        // Flush on busy cycle 5 of a DIVU
        send(6'h00, 6'h1b, 6'h1b, 1'b1, 1'b0, 1'b1, a);
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        #1 chk("flush_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy_after", 32'(busy), 32'd0);
        chk("flush_in_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("flush_stays_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Input offered during flush is dropped
        flush = 1'b1;
        op = 6'h23;
        in_valid = 1'b1;
        @(negedge clk);
        chk("flush_drop_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_drop_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Flush empties a stalled slot without handoff
        out_ready = 1'b0;
        send(6'h0c, 6'h00, 6'h24, 1'b0, 1'b0, 1'b0, a);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_slot_valid", 32'(out_valid), 32'd0);
        chk("flush_slot_multi", 32'(out_multi), 32'd0);
        @(posedge clk);
        #1;

        // Handoff of MULT coinciding with flush: delivered, no BUSY
        send(6'h00, 6'h18, 6'h18, 1'b1, 1'b0, 1'b1, a);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_handoff_busy", 32'(busy), 32'd0);
        chk("flush_handoff_valid", 32'(out_valid), 32'd0);
        chk("flush_handoff_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Decode table, including unknown ops and SPECIAL funct handling
        vt[0] = '{6'h3f, 6'h00, 6'h00, 1'b1};
        vt[1] = '{6'h00, 6'h21, 6'h21, 1'b0};
        vt[2] = '{6'h00, 6'h3f, RI ? 6'h00 : 6'h3f, 1'b1};
        vt[3] = '{6'h08, 6'h00, 6'h20, 1'b0};
        vt[4] = '{6'h0a, 6'h00, 6'h2a, 1'b0};
        vt[5] = '{6'h0e, 6'h00, 6'h26, 1'b0};
        vt[6] = '{6'h0d, 6'h00, 6'h25, 1'b0};
        vt[7] = '{6'h03, 6'h00, 6'h25, 1'b0};
        vt[8] = '{6'h28, 6'h00, 6'h21, 1'b0};
        vt[9] = '{6'h04, 6'h00, 6'h00, 1'b1};
        for (int i = 0; i < 10; i++)
            send(vt[i].o, vt[i].f, vt[i].ef, 1'b0, vt[i].ri & RI, 1'b1, a);
        @(negedge clk);
        @(posedge clk);
        #1;

        // Async reset in the middle of a DIV busy period
        send(6'h00, 6'h1a, 6'h1a, 1'b1, 1'b0, 1'b1, a);
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_funct", 32'(funct), 32'h00);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
